// File: rtl/cache_controller.sv
// Read-only, direct-mapped cache sequencer with 4-word blocks. It owns the tag/valid store,
// detects hit or miss, and refills a line from main memory. CACHE_STATS_EN adds the hit/miss counters.
module cache_controller #(
  parameter int ADDR_W   = 15,
  parameter int WORD_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic [ADDR_W-1:0]   cpu_addr,
  output logic                cpu_ready,
  output logic                cpu_valid,
  output logic [WORD_W-1:0]   cpu_rdata,
  output logic                cpu_hit,
  output logic [INDEX_W-1:0]  da_index,
  output logic                da_we,
  output logic [4*WORD_W-1:0] da_wdata,
  input  logic [4*WORD_W-1:0] da_rdata,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [4*WORD_W-1:0] mem_rdata,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, RESP} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0]   addr_q;
  logic [4*WORD_W-1:0] blk_q;
  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tags [LINES];

  logic [OFFSET_W-1:0] off;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic [3:0][WORD_W-1:0] da_words, blk_words;

  assign off       = addr_q[OFFSET_W-1:0];
  assign idx       = addr_q[OFFSET_W +: INDEX_W];
  assign tag       = addr_q[ADDR_W-1 -: TAG_W];
  assign hit       = valid[idx] && (tags[idx] == tag);
  assign da_words  = da_rdata;
  assign blk_words = blk_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (cpu_req) state_nx = LOOKUP;
      LOOKUP:   state_nx = hit ? RESP : MISS_REQ;
      MISS_REQ: if (mem_ack) state_nx = FILL;
      FILL:     state_nx = RESP;
      RESP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;

  // Reset clears every valid bit, so an interrupted fill never leaves a live line.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_q    <= '0;
      blk_q     <= '0;
      cpu_rdata <= '0;
      cpu_hit   <= 1'b0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE:     if (cpu_req) addr_q <= cpu_addr;
        LOOKUP:   if (hit) begin
                    cpu_rdata <= da_words[off];
                    cpu_hit   <= 1'b1;
                  end
        MISS_REQ: if (mem_ack) blk_q <= mem_rdata;
        FILL:     begin
                    cpu_rdata  <= blk_words[off];
                    cpu_hit    <= 1'b0;
                    valid[idx] <= 1'b1;
                  end
        default:  ;
      endcase
    end

  // Tags need no reset: they are qualified by valid.
  always_ff @(posedge clk)
    if (state == FILL) tags[idx] <= tag;

  assign cpu_ready = (state == IDLE);
  assign cpu_valid = (state == RESP);
  assign mem_req   = (state == MISS_REQ);
  assign da_we     = (state == FILL);
  assign da_index  = idx;
  assign da_wdata  = blk_q;
  assign mem_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

`ifdef CACHE_STATS_EN
  logic [15:0] hc, mc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hc <= '0;
      mc <= '0;
    end else if (state == RESP) begin
      if (cpu_hit) begin
        if (hc != 16'hFFFF) hc <= hc + 16'd1;
      end else begin
        if (mc != 16'hFFFF) mc <= mc + 16'd1;
      end
    end
  assign hit_cnt  = hc;
  assign miss_cnt = mc;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: behavioural data array, latency-programmable memory
// responder, and hand-derived expected words, latencies and counters.
module tb_cache_controller;
  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic [14:0]  cpu_addr;
  logic         cpu_ready, cpu_valid, cpu_hit;
  logic [31:0]  cpu_rdata;
  logic [9:0]   da_index;
  logic         da_we;
  logic [127:0] da_wdata, da_rdata;
  logic         mem_req, mem_ack;
  logic [14:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic [15:0]  hit_cnt, miss_cnt;

  cache_controller dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .da_index(da_index),
    .da_we(da_we), .da_wdata(da_wdata), .da_rdata(da_rdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Main-memory contents: every word encodes its own address.
  function automatic logic [31:0] mw(input logic [14:0] a);
    return 32'hA000_0000 + ({17'd0, a} << 4);
  endfunction
  assign mem_rdata = {mw(mem_addr + 15'd3), mw(mem_addr + 15'd2), mw(mem_addr + 15'd1), mw(mem_addr)};

  // Data array: combinational read, synchronous block write.
  logic [127:0] darr [1024];
  initial for (int i = 0; i < 1024; i++) darr[i] = '0;
  always @(posedge clk) if (da_we) darr[da_index] <= da_wdata;
  assign da_rdata = darr[da_index];

  // Responder: ack in the mem_lat-th cycle after mem_req rises.
  int   mem_lat = 3;
  int   rcnt = 0;
  logic ack_auto = 1'b0, ack_man = 1'b0;
  assign mem_ack = ack_auto | ack_man;
  always @(negedge clk) begin
    ack_auto = 1'b0;
    if (mem_req) begin
      rcnt++;
      if (rcnt == mem_lat + 1) ack_auto = 1'b1;
    end else rcnt = 0;
  end

  // Monitor of memory requests and array writes.
  int   req_cnt = 0, we_cnt = 0;
  logic req_d = 1'b0;
  logic [14:0] last_maddr = '0;
  logic [9:0]  we_idx = '0;
  always @(negedge clk) begin
    if (mem_req && !req_d) begin
      req_cnt++;
      last_maddr = mem_addr;
    end
    req_d = mem_req;
    if (da_we) begin
      we_cnt++;
      we_idx = da_index;
    end
  end

  // n = cycles from the accept edge to the cycle showing cpu_valid.
  task automatic rd(input logic [14:0] a, input bit hold, output logic [31:0] d,
                    output logic h, output int n);
    @(negedge clk);
    chk("ready_at_req", cpu_ready, 1'b1);
    cpu_req = 1'b1; cpu_addr = a;
    @(negedge clk);
    n = 1;
    if (hold) cpu_addr = a ^ 15'h0001;
    else      cpu_req = 1'b0;
    while (!cpu_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    cpu_req = 1'b0;
    chk("valid_seen", cpu_valid, 1'b1);
    d = cpu_rdata; h = cpu_hit;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [31:0] d;
  logic        h;
  int          n, rq0, we0;

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
    @(negedge clk);
    chk("rst_ready", cpu_ready, 1'b1);
    chk("rst_valid", cpu_valid, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_memreq", mem_req, 1'b0);
    chk("rst_maddr", mem_addr, 15'd0);
    chk("rst_dawe", da_we, 1'b0);
    chk("rst_hitcnt", hit_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Cold miss; accept, lookup, 3-cycle memory wait + ack cycle, fill, resp.
    mem_lat = 3;
    rd(15'd1024, 1'b0, d, h, n);
    chk("t1_maddr", last_maddr, 15'd1024);
    chk("t1_wecnt", we_cnt, 1);
    chk("t1_weidx", we_idx, 10'd256);
    chk("t1_rdata", d, mw(15'd1024));
    chk("t1_hit", h, 1'b0);
    chk("t1_lat", n, 7);

    rq0 = req_cnt;
    for (int i = 1; i < 4; i++) begin
      rd(15'd1024 + 15'(i), 1'b0, d, h, n);
      chk("t2_rdata", d, mw(15'd1024 + 15'(i)));
      chk("t2_hit", h, 1'b1);
      chk("t2_lat", n, 2);
    end
    chk("t2_noreq", req_cnt, rq0);
    chk("t2_wecnt", we_cnt, 1);

    // Conflict eviction within line 256.
    rd(15'd5120, 1'b0, d, h, n);
    chk("t3_hit", h, 1'b0);
    chk("t3_maddr", last_maddr, 15'd5120);
    chk("t3_rdata", d, mw(15'd5120));
    rd(15'd1024, 1'b0, d, h, n);
    chk("t3_evict_hit", h, 1'b0);
    chk("t3_evict_rdata", d, mw(15'd1024));

    // Reset in MISS_REQ: mem_req must fall without a clock edge.
    mem_lat = 20;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 15'd2048;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_inmiss", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t4_memreq_drop", mem_req, 1'b0);
    chk("t4_ready", cpu_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    mem_lat = 3;
    rd(15'd1025, 1'b0, d, h, n);
    chk("t4_reread_hit", h, 1'b0);
    chk("t4_reread_rdata", d, mw(15'd1025));

    // Stray ack in IDLE, then a held/changing cpu_req during a miss.
    @(negedge clk);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    chk("t5_ack_ready", cpu_ready, 1'b1);
    chk("t5_ack_memreq", mem_req, 1'b0);
    chk("t5_ack_valid", cpu_valid, 1'b0);
    chk("t5_ack_dawe", da_we, 1'b0);
    rq0 = req_cnt; we0 = we_cnt;
    rd(15'd3074, 1'b1, d, h, n);
    chk("t5_onereq", req_cnt, rq0 + 1);
    chk("t5_onewe", we_cnt, we0 + 1);
    chk("t5_rdata", d, mw(15'd3074));
    @(negedge clk);
    chk("t5_idle_after", cpu_ready, 1'b1);

    // Counter sweep from a clean reset: 4 blocks, 1 miss + 3 hits each.
    do_reset();
    mem_lat = 2;
    for (int i = 0; i < 16; i++) begin
      rd(15'd1024 + 15'(i), 1'b0, d, h, n);
      if (i == 0) chk("t6_lat", n, 6);
    end
    @(negedge clk);
`ifdef CACHE_STATS_EN
    chk("t6_hitcnt", hit_cnt, 16'd12);
    chk("t6_misscnt", miss_cnt, 16'd4);
`else
    chk("t6_hitcnt", hit_cnt, 16'd0);
    chk("t6_misscnt", miss_cnt, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
